// File: rtl/k_band_energy_computer.sv
// k_band_energy_computer: streams FFT bins, squares re/im, emits either the
// energy of every bin or the sum over bands of BINS_PER_BAND bins.
// Three stages: S1 input regs, S2 squares, S3 accumulate/saturate/output.

// One squaring lane: registers a*a as an unsigned 2W-bit value.
// The square of the most negative input (2^(2W-2)) still fits in 2W bits.
module k_band_sq_lane #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                en,
  input  logic signed [W-1:0] a,
  output logic [2*W-1:0]      sq
);
  logic signed [2*W-1:0] prod;

  assign prod = a * a;

  // S2 square register, advances with the pipeline
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  sq <= '0;
    else if (en)  sq <= $unsigned(prod);
  end
endmodule

module k_band_energy_computer #(
  parameter int IN_WIDTH      = 16,
  parameter int OUT_WIDTH     = 40,
  parameter int FFT_NUM_PTS   = 16,
  parameter int BINS_PER_BAND = 4
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [IN_WIDTH-1:0]                 in_re,
  input  logic [IN_WIDTH-1:0]                 in_im,
  input  logic                                in_valid,
  input  logic                                in_last,
  output logic                                in_ready,
  input  logic                                cfg_per_bin,
  output logic [OUT_WIDTH-1:0]                out_energy,
  output logic [$clog2(FFT_NUM_PTS)-1:0]      out_idx,
  output logic                                out_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                err_frame
);
  localparam int NLANE  = 2;                       // lane 0 = re, lane 1 = im
  localparam int STAGES = 2;                       // S1, S2 valids; S3 is out_valid
  localparam int CW     = $clog2(FFT_NUM_PTS);
  localparam int LB     = $clog2(BINS_PER_BAND);
  localparam int SW     = 2*IN_WIDTH;
  localparam int AW     = SW + LB + 1;
  localparam int WW     = AW + OUT_WIDTH;          // wide enough to compare both
  localparam logic [CW-1:0] LAST_BIN = CW'(FFT_NUM_PTS-1);
  localparam logic [CW-1:0] BMASK    = CW'(BINS_PER_BAND-1);
  localparam logic [WW-1:0] OMAX     = WW'({OUT_WIDTH{1'b1}});

  // Elaboration-time parameter guards
  if (OUT_WIDTH < 2*IN_WIDTH) begin : g_bad_ow
    $error("OUT_WIDTH must be >= 2*IN_WIDTH");
  end
  if (FFT_NUM_PTS < 2 || (FFT_NUM_PTS & (FFT_NUM_PTS-1)) != 0) begin : g_bad_n
    $error("FFT_NUM_PTS must be a power of 2 and >= 2");
  end
  if ((BINS_PER_BAND & (BINS_PER_BAND-1)) != 0 || BINS_PER_BAND > FFT_NUM_PTS) begin : g_bad_b
    $error("BINS_PER_BAND must be a power of 2 dividing FFT_NUM_PTS");
  end

  // Per-bin control travelling alongside the data
  typedef struct packed {
    logic          emit;   // this bin produces a result
    logic          start;  // first bin of a result: ignore old accumulator
    logic          last;   // result closes the frame
    logic          err;    // frame length mismatch
    logic [CW-1:0] idx;    // bin or band index
  } meta_t;

  logic                         rdy_q, stall, adv, acc_in;
  logic [STAGES-1:0]            vld_pipe;
  logic [CW-1:0]                cnt_q;
  logic                         mode_q;
  logic                         first, mode_eff, at_end, end_frame;
  logic [CW-1:0]                bpos;
  meta_t                        m_in, m1, m2;
  logic [NLANE-1:0][IN_WIDTH-1:0] iq1;
  logic [NLANE-1:0][SW-1:0]       sq2;
  logic [AW-1:0]                acc_q, base, sum;
  logic [WW-1:0]                sum_w;
  logic [OUT_WIDTH-1:0]         sat;

  // Handshake: the whole pipe freezes while a result waits downstream
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = rdy_q & adv;
  assign acc_in   = in_valid & in_ready;

  // Frame/band bookkeeping for the bin being offered
  always_comb begin
    first      = (cnt_q == '0);
    mode_eff   = first ? cfg_per_bin : mode_q;
    at_end     = (cnt_q == LAST_BIN);
    end_frame  = in_last | at_end;
    bpos       = cnt_q & BMASK;
    m_in       = '0;
    m_in.err   = in_last ^ at_end;
    m_in.last  = end_frame;
    m_in.start = mode_eff | (bpos == '0);
    m_in.emit  = mode_eff | end_frame | (bpos == BMASK);
    m_in.idx   = mode_eff ? cnt_q : (cnt_q >> LB);
  end

  // in_ready stays low until the first edge after reset release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdy_q <= 1'b0;
    else         rdy_q <= 1'b1;
  end

  // Bin counter and frame mode; mode latches only on bin 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      mode_q <= 1'b0;
    end else if (acc_in) begin
      cnt_q <= end_frame ? '0 : cnt_q + CW'(1);
      if (first) mode_q <= cfg_per_bin;
    end
  end

  // S1/S2 valid shift register and control metadata
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      iq1      <= '0;
      m1       <= '0;
      m2       <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-2:0], acc_in};
      m2       <= m1;
      if (acc_in) begin
        iq1 <= {in_im, in_re};
        m1  <= m_in;
      end
    end
  end

  // S2 squaring lanes
  for (genvar l = 0; l < NLANE; l++) begin : g_lane
    k_band_sq_lane #(.W(IN_WIDTH)) u_lane (
      .clk    (clk),
      .resetn (resetn),
      .en     (adv),
      .a      (iq1[l]),
      .sq     (sq2[l])
    );
  end

  // S3 arithmetic: band accumulate then clamp to the output width
  always_comb begin
    base  = m2.start ? '0 : acc_q;
    sum   = base + AW'(sq2[0]) + AW'(sq2[1]);
    sum_w = WW'(sum);
    sat   = (sum_w > OMAX) ? '1 : sum_w[OUT_WIDTH-1:0];
  end

  // S3 output register and accumulator; err_frame is a single-cycle pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q      <= '0;
      out_valid  <= 1'b0;
      out_energy <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      err_frame  <= 1'b0;
    end else if (adv) begin
      out_valid <= vld_pipe[STAGES-1] & m2.emit;
      err_frame <= vld_pipe[STAGES-1] & m2.emit & m2.err;
      if (vld_pipe[STAGES-1]) begin
        if (m2.emit) begin
          out_energy <= sat;
          out_idx    <= m2.idx;
          out_last   <= m2.last;
          acc_q      <= '0;
        end else begin
          acc_q <= sum;
        end
      end
    end else begin
      err_frame <= 1'b0;
    end
  end
endmodule

// File: tb/tb_k_band_energy_computer.sv
// Directed bench for k_band_energy_computer: hand-computed vectors plus a
// tiny re^2+im^2 model for the longer frames.
module tb_k_band_energy_computer;
  logic        clk, resetn;
  logic [15:0] in_re, in_im;
  logic        in_valid, in_last, cfg_per_bin, out_ready;
  logic        in_ready, out_last, out_valid, err_frame;
  logic [39:0] out_energy;
  logic [3:0]  out_idx;
  logic        rdy32, last32, vld32, err32;
  logic [31:0] e32;
  logic [3:0]  idx32;

  typedef struct { longint e; longint e32; int idx; bit last; bit err; } res_t;
  res_t   rq[$];
  longint cyc, first_vld_cyc;
  int     n_errp, last_acc;
  int     n_chk, n_fail;
  logic   vld_d, pend_err;

  k_band_energy_computer dut (
    .clk(clk), .resetn(resetn), .in_re(in_re), .in_im(in_im),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .cfg_per_bin(cfg_per_bin), .out_energy(out_energy), .out_idx(out_idx),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .err_frame(err_frame));

  k_band_energy_computer #(.OUT_WIDTH(32)) dut32 (
    .clk(clk), .resetn(resetn), .in_re(in_re), .in_im(in_im),
    .in_valid(in_valid), .in_last(in_last), .in_ready(rdy32),
    .cfg_per_bin(cfg_per_bin), .out_energy(e32), .out_idx(idx32),
    .out_last(last32), .out_valid(vld32), .out_ready(out_ready),
    .err_frame(err32));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  always @(posedge clk) cyc <= cyc + 1;

  // Result capture on the falling edge: every transfer, with its err pulse
  always @(negedge clk) begin
    vld_d <= out_valid;
    if (out_valid && !vld_d) first_vld_cyc <= cyc;
    if (err_frame) n_errp <= n_errp + 1;
    if (out_valid && out_ready) begin
      rq.push_back('{e: longint'(out_energy), e32: longint'(e32), idx: int'(out_idx),
                     last: out_last, err: pend_err | err_frame});
      pend_err <= 1'b0;
    end else if (out_valid && err_frame) pend_err <= 1'b1;
    if (!resetn) pend_err <= 1'b0;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint en(input int re, input int im);
    longint r, i;
    r = longint'(re); i = longint'(im);
    return r*r + i*i;
  endfunction

  task automatic send(input int re, input int im, input bit last, input bit pb);
    int n;
    in_re = 16'(re); in_im = 16'(im); in_last = last; cfg_per_bin = pb; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    last_acc = int'(cyc);
  endtask

  task automatic wait_res(input string tag, input int want);
    int n;
    n = 0;
    while (rq.size() < want && n < 200) begin @(negedge clk); #1; n++; end
    chk(tag, rq.size(), want);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    rq.delete();
  endtask

  initial begin
    int a0, ep;
    longint b0, b1, fe;
    int fi;
    n_chk = 0; n_fail = 0; cyc = 0; first_vld_cyc = 0; n_errp = 0;
    vld_d = 1'b0; pend_err = 1'b0;
    resetn = 1'b0; in_valid = 1'b0; in_last = 1'b0; cfg_per_bin = 1'b0;
    in_re = '0; in_im = '0; out_ready = 1'b1;

    // reset state
    #3;
    chk("rst_ovld", out_valid, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_energy", out_energy, 0);
    chk("rst_err", err_frame, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    chk("rdy_before_edge", in_ready, 0);
    @(posedge clk); #1;
    chk("rdy_after_edge", in_ready, 1);

    // per-bin: 2740, 10377, latency 2
    send('h0034, 'h0006, 0, 1); a0 = last_acc;
    send('hFFE8, 'h0063, 0, 1);
    wait_res("pb_cnt", 2);
    if (rq.size() >= 2) begin
      chk("pb_e0", rq[0].e, 2740);   chk("pb_i0", rq[0].idx, 0);
      chk("pb_e1", rq[1].e, 10377);  chk("pb_i1", rq[1].idx, 1);
      chk("pb_last0", rq[0].last, 0);
    end
    chk("pb_latency", first_vld_cyc - longint'(a0), 2);
    do_reset();

    // band: one result 24487
    send('h0034, 'h0006, 0, 0); send('hFFE8, 'h0063, 0, 0);
    send('h0017, 'hFF9D, 0, 0); send('hFFE4, 'h0010, 0, 0);
    wait_res("band_cnt", 1);
    repeat (5) @(negedge clk);
    chk("band_only_one", rq.size(), 1);
    if (rq.size() >= 1) begin
      chk("band_e", rq[0].e, 24487); chk("band_i", rq[0].idx, 0);
    end
    do_reset();

    // extremes: 2^33 at 40 bits, saturated at 32 bits
    repeat (4) send('h8000, 'h8000, 0, 0);
    wait_res("ext_cnt", 1);
    if (rq.size() >= 1) begin
      chk("ext_e40", rq[0].e, 64'h0200000000);
      chk("ext_e32", rq[0].e32, 64'hFFFFFFFF);
    end
    do_reset();

    // full 16-bin frame, band mode
    ep = n_errp;
    for (int i = 0; i < 16; i++) send(i*100 - 700, i*37 - 300, i == 15, 0);
    wait_res("full_cnt", 4);
    repeat (3) @(negedge clk);
    chk("full_only4", rq.size(), 4);
    for (int b = 0; b < 4 && b < rq.size(); b++) begin
      longint s;
      s = 0;
      for (int k = 0; k < 4; k++) s += en((b*4+k)*100 - 700, (b*4+k)*37 - 300);
      chk($sformatf("full_e%0d", b), rq[b].e, s);
      chk($sformatf("full_i%0d", b), rq[b].idx, b);
      chk($sformatf("full_last%0d", b), rq[b].last, b == 3);
    end
    chk("full_no_err", n_errp - ep, 0);
    do_reset();

    // early in_last on bin 5
    ep = n_errp;
    for (int i = 0; i < 6; i++) send(i*11 - 30, 20 - i*9, i == 5, 0);
    send(5, 5, 0, 1);
    wait_res("early_cnt", 3);
    b0 = 0; b1 = 0;
    for (int i = 0; i < 4; i++) b0 += en(i*11 - 30, 20 - i*9);
    for (int i = 4; i < 6; i++) b1 += en(i*11 - 30, 20 - i*9);
    if (rq.size() >= 3) begin
      chk("early_e0", rq[0].e, b0);    chk("early_last0", rq[0].last, 0);
      chk("early_e1", rq[1].e, b1);    chk("early_i1", rq[1].idx, 1);
      chk("early_last1", rq[1].last, 1); chk("early_err1", rq[1].err, 1);
      chk("early_next_i", rq[2].idx, 0); chk("early_next_e", rq[2].e, 50);
    end
    chk("early_errp", n_errp - ep, 1);
    do_reset();

    // 16 bins with no in_last: forced frame end
    ep = n_errp;
    for (int i = 0; i < 16; i++) send(i, -i, 0, 1);
    wait_res("nolast_cnt", 16);
    if (rq.size() >= 16) begin
      chk("nolast_last14", rq[14].last, 0);
      chk("nolast_last15", rq[15].last, 1);
      chk("nolast_err15", rq[15].err, 1);
      chk("nolast_e15", rq[15].e, 450);
    end
    chk("nolast_errp", n_errp - ep, 1);
    do_reset();

    // backpressure: 5-cycle out_ready drop mid-stream
    fork
      begin
        for (int i = 0; i < 16; i++) send(i*3 - 20, 7 - i*5, i == 15, 1);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        chk("stall_ovld", out_valid, 1);
        fe = longint'(out_energy); fi = int'(out_idx);
        chk("stall_e_model", fe, en(fi*3 - 20, 7 - fi*5));
        repeat (5) begin
          @(negedge clk);
          chk("stall_rdy", in_ready, 0);
          chk("stall_e_hold", out_energy, fe);
          chk("stall_i_hold", out_idx, fi);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_res("stall_cnt", 16);
    repeat (4) @(negedge clk);
    chk("stall_only16", rq.size(), 16);
    for (int i = 0; i < 16 && i < rq.size(); i++) begin
      chk($sformatf("stall_i%0d", i), rq[i].idx, i);
      chk($sformatf("stall_e%0d", i), rq[i].e, en(i*3 - 20, 7 - i*5));
    end
    if (rq.size() >= 16) chk("stall_last15", rq[15].last, 1);
    do_reset();

    // asynchronous reset mid-frame with a held result
    out_ready = 1'b0;
    send(9, 12, 0, 1); send(1, 1, 0, 1); send(2, 2, 0, 1);
    #3;
    chk("pre_rst_ovld", out_valid, 1);
    chk("pre_rst_e", out_energy, 225);
    resetn = 1'b0;
    #1;
    chk("mid_rst_ovld", out_valid, 0);
    chk("mid_rst_e", out_energy, 0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_err", err_frame, 0);
    chk("mid_rst_rdy", in_ready, 0);
    @(posedge clk); #1 resetn = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rq.delete();
    send(3, 4, 0, 1);
    wait_res("post_rst_cnt", 1);
    repeat (4) @(negedge clk);
    chk("post_rst_only1", rq.size(), 1);
    if (rq.size() >= 1) begin
      chk("post_rst_i", rq[0].idx, 0);
      chk("post_rst_e", rq[0].e, 25);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
